// File: rtl/jt89_wr_sched.sv
// Write scheduler in front of the jt89 PSG register port.
// Two requesters (A, B) each feed a small byte FIFO. One shared wr_n/din bus
// carries their bytes as clean pulses: wr_n is low for WR_LOW cycles, then high
// for at least WR_GAP cycles. A latch byte (bit7=1) locks the bus to its
// requester so that the following data bytes are not split by the other side.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   a_din/a_valid/a_ready  requester A byte stream (ready = FIFO not full)
//   b_din/b_valid/b_ready  requester B byte stream
//   psg_din, psg_wr_n   to jt89 din / wr_n
//   idle                both FIFOs empty and scheduler in IDLE
module jt89_wr_sched #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned WR_LOW  = 2,
   parameter int unsigned WR_GAP  = 2,
   parameter int unsigned LOCK_TO = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] a_din,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [7:0] b_din,
   input  logic       b_valid,
   output logic       b_ready,
   output logic [7:0] psg_din,
   output logic       psg_wr_n,
   output logic       idle
);

   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = $clog2(DEPTH + 1);
   localparam int unsigned CMAX = (WR_LOW > WR_GAP) ? WR_LOW : WR_GAP;
   localparam int unsigned CNTW = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam int unsigned TOW  = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOW  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   // FIFO storage, index 0 = A, 1 = B
   logic [7:0]    mem_q  [2][DEPTH];
   logic [PW-1:0] wp_q   [2];
   logic [PW-1:0] rp_q   [2];
   logic [CW-1:0] fcnt_q [2];

   logic [7:0]    din_c  [2];
   logic [7:0]    head_c [2];
   logic [1:0]    vld_c, full_c, ne_c, push_c, pop_c;

   // Scheduler state
   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [7:0]      din_q, din_d;
   logic            wr_n_q, wr_n_d;
   logic            lock_q, lock_d;
   logic            owner_q, owner_d;
   logic            last_q, last_d;
   logic [TOW-1:0]  to_q, to_d;
   logic            sel_c, sel_vld_c, rel_c;

   assign din_c[0] = a_din;
   assign din_c[1] = b_din;
   assign vld_c    = {b_valid, a_valid};

   // FIFO status decode
   always_comb begin
      for (int r = 0; r < 2; r++) begin
         full_c[r] = (fcnt_q[r] == CW'(DEPTH));
         ne_c[r]   = (fcnt_q[r] != '0);
         push_c[r] = vld_c[r] & ~full_c[r];
         head_c[r] = mem_q[r][rp_q[r]];
      end
   end

   // FIFO storage write; contents need no reset
   always_ff @(posedge clk) begin
      for (int r = 0; r < 2; r++) begin
         if (push_c[r]) mem_q[r][wp_q[r]] <= din_c[r];
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 2; r++) begin
            wp_q[r]   <= '0;
            rp_q[r]   <= '0;
            fcnt_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < 2; r++) begin
            if (push_c[r]) wp_q[r] <= wp_q[r] + PW'(1);
            if (pop_c[r])  rp_q[r] <= rp_q[r] + PW'(1);
            case ({push_c[r], pop_c[r]})
               2'b10:   fcnt_q[r] <= fcnt_q[r] + CW'(1);
               2'b01:   fcnt_q[r] <= fcnt_q[r] - CW'(1);
               default: fcnt_q[r] <= fcnt_q[r];
            endcase
         end
      end
   end

   // Scheduler state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         din_q   <= '0;
         wr_n_q  <= 1'b1;
         lock_q  <= 1'b0;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         din_q   <= din_d;
         wr_n_q  <= wr_n_d;
         lock_q  <= lock_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         to_q    <= to_d;
      end
   end

   // Next state: arbitration, pulse timing, lock handling
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      din_d     = din_q;
      wr_n_d    = wr_n_q;
      lock_d    = lock_q;
      owner_d   = owner_q;
      last_d    = last_q;
      to_d      = to_q;
      pop_c     = 2'b00;
      sel_c     = 1'b0;
      sel_vld_c = 1'b0;
      rel_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (lock_q) begin
               if (ne_c[owner_q]) begin
                  if (!head_c[owner_q][7]) begin
                     sel_vld_c = 1'b1;
                     sel_c     = owner_q;
                  end else begin
                     // a new latch from the owner ends its own lock
                     rel_c = 1'b1;
                  end
               end else if (to_q == TOW'(LOCK_TO - 1)) begin
                  lock_d = 1'b0;
                  to_d   = '0;
               end else begin
                  to_d = to_q + TOW'(1);
               end
            end
            if (!lock_q || rel_c) begin
               if (ne_c[0] && ne_c[1]) begin
                  sel_vld_c = 1'b1;
                  sel_c     = ~last_q;
               end else if (ne_c[0]) begin
                  sel_vld_c = 1'b1;
                  sel_c     = 1'b0;
               end else if (ne_c[1]) begin
                  sel_vld_c = 1'b1;
                  sel_c     = 1'b1;
               end
            end
            if (sel_vld_c) begin
               pop_c[sel_c] = 1'b1;
               din_d        = head_c[sel_c];
               wr_n_d       = 1'b0;
               cnt_d        = CNTW'(WR_LOW - 1);
               state_d      = S_LOW;
               last_d       = sel_c;
               to_d         = '0;
               lock_d       = head_c[sel_c][7] | (lock_q & ~rel_c);
               if (head_c[sel_c][7]) owner_d = sel_c;
            end
         end
         S_LOW: begin
            if (cnt_q == '0) begin
               wr_n_d  = 1'b1;
               cnt_d   = CNTW'(WR_GAP - 1);
               state_d = S_GAP;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CNTW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign a_ready  = ~full_c[0];
   assign b_ready  = ~full_c[1];
   assign psg_din  = din_q;
   assign psg_wr_n = wr_n_q;
   assign idle     = (state_q == S_IDLE) & ~ne_c[0] & ~ne_c[1];

endmodule

// File: tb/tb_jt89_wr_sched.sv
// Directed bench for jt89_wr_sched (LOCK_TO shortened to 8).
// A negedge monitor logs every falling edge of psg_wr_n (byte, cycle) and
// every low-pulse width; the test sequence checks against hand-computed values.
module tb_jt89_wr_sched;

   localparam int unsigned LOCK_TO = 8;
   localparam int SP    = 5;   // WR_LOW + WR_GAP + 1
   localparam int SP_TO = 13;  // SP + LOCK_TO

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_din = '0;
   logic       a_valid = 1'b0;
   logic       a_ready;
   logic [7:0] b_din = '0;
   logic       b_valid = 1'b0;
   logic       b_ready;
   logic [7:0] psg_din;
   logic       psg_wr_n;
   logic       idle;

   always #5 clk = ~clk;

   jt89_wr_sched #(
      .DEPTH  (4),
      .WR_LOW (2),
      .WR_GAP (2),
      .LOCK_TO(LOCK_TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .a_din   (a_din),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .b_din   (b_din),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .psg_din (psg_din),
      .psg_wr_n(psg_wr_n),
      .idle    (idle)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // bus monitor
   logic [7:0] wr_byte_q [$];
   int         wr_cyc_q  [$];
   int         low_w_q   [$];
   int         cyc       = 0;
   int         low_cnt   = 0;
   logic       prev_wr_n = 1'b1;

   always @(negedge clk) begin
      cyc++;
      if (prev_wr_n && !psg_wr_n) begin
         wr_byte_q.push_back(psg_din);
         wr_cyc_q.push_back(cyc);
      end
      if (!psg_wr_n) begin
         low_cnt++;
      end else begin
         if (!prev_wr_n) low_w_q.push_back(low_cnt);
         low_cnt = 0;
      end
      prev_wr_n = psg_wr_n;
   end

   function automatic logic [31:0] byte_at(input int i);
      if (i < wr_byte_q.size()) return 32'(wr_byte_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] gap_at(input int i);
      if (i + 1 < wr_cyc_q.size()) return 32'(wr_cyc_q[i+1] - wr_cyc_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] width_at(input int i);
      if (i < low_w_q.size()) return 32'(low_w_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      a_valid = 1'b0;
      b_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push_a(input logic [7:0] d);
      a_din   = d;
      a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
   endtask

   task automatic push_b(input logic [7:0] d);
      b_din   = d;
      b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
   endtask

   task automatic wait_writes(input int n, input int budget, input string tag);
      int k = 0;
      while (wr_byte_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(wr_byte_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (!(idle && psg_wr_n) && k < budget) begin
         tick();
         k++;
      end
      chk(tag, 32'(idle), 32'd1);
   endtask

   initial begin
      int b;
      int wb;
      int k;

      // reset state
      do_reset();
      chk("rst_wr_n",    32'(psg_wr_n), 32'd1);
      chk("rst_din",     32'(psg_din),  32'h00);
      chk("rst_idle",    32'(idle),     32'd1);
      chk("rst_a_ready", 32'(a_ready),  32'd1);
      chk("rst_b_ready", 32'(b_ready),  32'd1);

      // 1: latch + data from A
      do_reset();
      b  = wr_byte_q.size();
      wb = low_w_q.size();
      push_a(8'h80);
      push_a(8'h3F);
      wait_writes(b + 2, 100, "t1_wait");
      wait_idle(100, "t1_idle");
      chk("t1_byte0", byte_at(b),     32'h80);
      chk("t1_byte1", byte_at(b + 1), 32'h3F);
      chk("t1_space", gap_at(b),      32'(SP));
      chk("t1_low0",  width_at(wb),     32'd2);
      chk("t1_low1",  width_at(wb + 1), 32'd2);

      // 2: simultaneous push after reset, A wins; B waits out A's lock
      do_reset();
      b = wr_byte_q.size();
      a_din = 8'h9F; a_valid = 1'b1;
      b_din = 8'hBF; b_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      wait_writes(b + 2, 200, "t2_wait");
      chk("t2_byte0", byte_at(b),     32'h9F);
      chk("t2_byte1", byte_at(b + 1), 32'hBF);
      chk("t2_space", gap_at(b),      32'(SP_TO));

      // 3: lock keeps B out until A's data byte is issued
      do_reset();
      b = wr_byte_q.size();
      push_a(8'h85);
      push_b(8'hDF);
      tick();
      tick();
      push_a(8'h12);
      wait_writes(b + 3, 200, "t3_wait");
      chk("t3_byte0", byte_at(b),     32'h85);
      chk("t3_byte1", byte_at(b + 1), 32'h12);
      chk("t3_byte2", byte_at(b + 2), 32'hDF);

      // 4: lock timeout releases to B
      do_reset();
      b = wr_byte_q.size();
      push_a(8'h85);
      push_b(8'hDF);
      wait_writes(b + 2, 200, "t4_wait");
      chk("t4_byte0", byte_at(b),     32'h85);
      chk("t4_byte1", byte_at(b + 1), 32'hDF);
      chk("t4_space", gap_at(b),      32'(SP_TO));

      // 5: FIFO fills, 6th byte waits for space
      do_reset();
      b = wr_byte_q.size();
      for (int i = 0; i < 5; i++) begin
         a_din   = 8'(i + 1);
         a_valid = 1'b1;
         chk("t5_ready", 32'(a_ready), 32'd1);
         tick();
      end
      a_din = 8'h06;
      chk("t5_full", 32'(a_ready), 32'd0);
      k = 0;
      while (!a_ready && k < 50) begin
         tick();
         k++;
      end
      chk("t5_rise", 32'(a_ready), 32'd1);
      tick();
      a_valid = 1'b0;
      wait_writes(b + 6, 200, "t5_wait");
      for (int i = 0; i < 6; i++) chk("t5_byte", byte_at(b + i), 32'(i + 1));
      for (int i = 0; i < 5; i++) chk("t5_space", gap_at(b + i), 32'(SP));
      wait_idle(100, "t5_idle");

      // 6: reset in the middle of a pulse
      do_reset();
      a_din = 8'h01; b_din = 8'h03; a_valid = 1'b1; b_valid = 1'b1;
      tick();
      a_din = 8'h02; b_din = 8'h04;
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      k = 0;
      while (psg_wr_n && k < 50) begin
         tick();
         k++;
      end
      chk("t6_low_seen", 32'(psg_wr_n), 32'd0);
      rst = 1'b1;
      tick();
      chk("t6_wr_n",    32'(psg_wr_n), 32'd1);
      chk("t6_idle",    32'(idle),     32'd1);
      chk("t6_a_ready", 32'(a_ready),  32'd1);
      chk("t6_b_ready", 32'(b_ready),  32'd1);
      chk("t6_din",     32'(psg_din),  32'h00);
      rst = 1'b0;
      b = wr_byte_q.size();
      repeat (40) tick();
      chk("t6_no_wr", 32'(wr_byte_q.size()), 32'(b));
      chk("t6_idle2", 32'(idle), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
